// File: rtl/tl_cntr_timed_left.sv
// rtl/tl_cntr_timed_left.sv - timed four-sensor traffic-light controller with latched left turns
//
// Purpose: Moore FSM that rotates right-of-way between road A and road B.
//   Each road runs green -> yellow -> (optional left arrow -> yellow) before
//   handing over to the other road. Phase durations are counted in ticks of an
//   external timebase. Left-turn requests are latched until served.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset (forces AG, clears timer and requests)
//   tick     in   timebase enable; timer and transitions advance only when high
//   Ta, Tb   in   through-traffic present on road A / road B
//   Tal, Tbl in   left-turn request on road A / road B
//   La, Lb   out  lamp code: 00 green, 01 yellow, 10 left arrow, 11 red
//   state_o  out  current FSM state
module tl_cntr_timed_left #(
  parameter int CW        = 4,
  parameter int MIN_GREEN = 3,
  parameter int MAX_GREEN = 8,
  parameter int YELLOW    = 2,
  parameter int LEFT_TIME = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       Ta,
  input  logic       Tal,
  input  logic       Tb,
  input  logic       Tbl,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    AG  = 3'd0,
    AY1 = 3'd1,
    AL  = 3'd2,
    AY2 = 3'd3,
    BG  = 3'd4,
    BY1 = 3'd5,
    BL  = 3'd6,
    BY2 = 3'd7
  } state_t;

  // Terminal counts: the tick that completes N ticks in a phase sees cnt == N-1.
  localparam logic [CW-1:0] MIN_M1  = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_M1  = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] YEL_M1  = CW'(YELLOW - 1);
  localparam logic [CW-1:0] LEFT_M1 = CW'(LEFT_TIME - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t        state_q, state_d;
  logic [CW-1:0] cnt;
  logic          req_a, req_b;

  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        AG:  if ((cnt >= MIN_M1 && !Ta) || cnt == MAX_M1) state_d = AY1;
        AY1: if (cnt == YEL_M1) state_d = req_a ? AL : BG;
        AL:  if (cnt == LEFT_M1) state_d = AY2;
        AY2: if (cnt == YEL_M1) state_d = BG;
        BG:  if ((cnt >= MIN_M1 && !Tb) || cnt == MAX_M1) state_d = BY1;
        BY1: if (cnt == YEL_M1) state_d = req_b ? BL : AG;
        BL:  if (cnt == LEFT_M1) state_d = BY2;
        BY2: if (cnt == YEL_M1) state_d = AG;
        default: state_d = AG;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= AG;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt <= '0;
      end else if (tick && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Requests are sampled every edge regardless of tick. Clearing on entry to
  // the left phase takes priority over a coincident set, so a held request
  // is served once per road cycle rather than repeatedly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_a <= 1'b0;
      req_b <= 1'b0;
    end else begin
      if (state_d == AL && state_q != AL) begin
        req_a <= 1'b0;
      end else if (Tal && state_q != AL) begin
        req_a <= 1'b1;
      end
      if (state_d == BL && state_q != BL) begin
        req_b <= 1'b0;
      end else if (Tbl && state_q != BL) begin
        req_b <= 1'b1;
      end
    end
  end

  always_comb begin
    La = 2'b11;
    Lb = 2'b11;
    unique case (state_q)
      AG:       La = 2'b00;
      AY1, AY2: La = 2'b01;
      AL:       La = 2'b10;
      BG:       Lb = 2'b00;
      BY1, BY2: Lb = 2'b01;
      BL:       Lb = 2'b10;
      default: begin
        La = 2'b11;
        Lb = 2'b11;
      end
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_tl_cntr_timed_left.sv
// tb/tb_tl_cntr_timed_left.sv - self-checking bench for tl_cntr_timed_left
module tb_tl_cntr_timed_left;

  localparam int CW        = 4;
  localparam int MIN_GREEN = 3;
  localparam int MAX_GREEN = 6;
  localparam int YELLOW    = 2;
  localparam int LEFT_TIME = 2;

  logic       clk;
  logic       reset_n;
  logic       tick;
  logic       Ta, Tal, Tb, Tbl;
  logic [1:0] La, Lb;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;

  tl_cntr_timed_left #(
    .CW(CW), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
    .YELLOW(YELLOW), .LEFT_TIME(LEFT_TIME)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick),
    .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
    .La(La), .Lb(Lb), .state_o(state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit         ta, tal, tb, tbl;
    logic [2:0] exp_state;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Lamp codes from the state table: active road shows its phase lamp, other road red.
  function automatic logic [1:0] lamp_of(input int s, input int road);
    int phase;
    if (s / 4 != road) return 2'b11;
    phase = s % 4;
    if (phase == 0) return 2'b00;
    if (phase == 2) return 2'b10;
    return 2'b01;
  endfunction

  task automatic check_all(input string name, input int exp_s);
    check({name, ".state"}, 32'(state_o), 32'(exp_s));
    check({name, ".La"}, 32'(La), 32'(lamp_of(exp_s, 0)));
    check({name, ".Lb"}, 32'(Lb), 32'(lamp_of(exp_s, 1)));
  endtask

  task automatic add(input bit ta, input bit tal, input bit tb, input bit tbl,
                     input int exp_s, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.ta = ta; v.tal = tal; v.tb = tb; v.tbl = tbl;
      v.exp_state = 3'(exp_s);
      vecs.push_back(v);
    end
  endtask

  task automatic drive(input bit ta, input bit tal, input bit tb, input bit tbl, input bit tk);
    Ta = ta; Tal = tal; Tb = tb; Tbl = tbl; tick = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Ta = 0; Tal = 0; Tb = 0; Tbl = 0; tick = 0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Behavioural model: road + phase kind + elapsed ticks, requests as flags.
  int m_road, m_phase, m_ticks;
  bit m_req[2];

  function automatic void model_reset();
    m_road = 0; m_phase = 0; m_ticks = 0;
    m_req[0] = 0; m_req[1] = 0;
  endfunction

  function automatic void model_step(input bit ta, input bit tal, input bit tb,
                                     input bit tbl, input bit tk);
    int nroad, nphase, done;
    bit traffic, in_left[2], enter_left[2], tl[2];
    nroad = m_road; nphase = m_phase;
    traffic = (m_road == 0) ? ta : tb;
    done = m_ticks + 1;
    if (tk) begin
      case (m_phase)
        0: if ((done >= MIN_GREEN && !traffic) || done >= MAX_GREEN) nphase = 1;
        1: if (done >= YELLOW) begin
             if (m_req[m_road]) nphase = 2;
             else begin nroad = 1 - m_road; nphase = 0; end
           end
        2: if (done >= LEFT_TIME) nphase = 3;
        default: if (done >= YELLOW) begin nroad = 1 - m_road; nphase = 0; end
      endcase
    end
    tl[0] = tal; tl[1] = tbl;
    for (int r = 0; r < 2; r++) begin
      in_left[r]    = (m_road == r && m_phase == 2);
      enter_left[r] = (nroad == r && nphase == 2 && !in_left[r]);
      if (enter_left[r]) m_req[r] = 0;
      else if (!in_left[r] && tl[r]) m_req[r] = 1;
    end
    if (nroad != m_road || nphase != m_phase) m_ticks = 0;
    else if (tk) m_ticks++;
    m_road = nroad; m_phase = nphase;
  endfunction

  initial begin
    int prev, al_seen, rounds, hit;
    bit ra, rla, rb, rlb, rt;
    reset_n = 1'b1;
    Ta = 0; Tal = 0; Tb = 0; Tbl = 0; tick = 0;

    // Reset state, asserted asynchronously between edges.
    #2 reset_n = 1'b0;
    #1 check_all("reset_async", 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table: basic rotation, held Ta, left pulse served on next A cycle only.
    add(0,0,1,0, 0,2); add(0,0,1,0, 1,2); add(0,0,1,0, 4,2);
    add(0,1,1,0, 4,1); add(0,0,1,0, 4,3); add(0,0,1,0, 5,2);
    add(0,0,1,0, 0,3); add(0,0,1,0, 1,2); add(0,0,1,0, 2,2);
    add(0,0,1,0, 3,2); add(0,0,1,0, 4,1);
    add(0,0,0,0, 4,2); add(0,0,0,0, 5,2); add(0,0,0,0, 0,3);
    add(0,0,0,0, 1,2); add(0,0,0,0, 4,3); add(0,0,0,0, 5,2);
    add(1,0,0,0, 0,6); add(1,0,0,0, 1,1);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ta, vecs[i].tal, vecs[i].tb, vecs[i].tbl, 1'b1);
      check_all($sformatf("vec%0d", i), int'(vecs[i].exp_state));
    end

    // tick every third cycle: AG spans 9 clocks, state moves only on tick edges.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      drive(0, 0, 1, 0, (i % 3) == 0);
      check_all($sformatf("tick3_e%0d", i), (i < 9) ? 0 : 1);
    end

    // Tal held permanently: one left phase per A cycle, request cleared on entry.
    do_reset();
    prev = 0; al_seen = 0; rounds = 0;
    for (int i = 0; i < 80; i++) begin
      drive(0, 1, 0, 0, 1'b1);
      if (state_o == 3'd2 && prev != 2) begin
        al_seen++;
        check("req_a_cleared_in_al", 32'(dut.req_a), 32'd0);
      end
      if (state_o == 3'd4 && prev != 4) begin
        check("al_once_per_a_cycle", 32'(al_seen), 32'd1);
        al_seen = 0;
        rounds++;
      end
      prev = int'(state_o);
    end
    check("tal_held_rounds_ge3", 32'(rounds >= 3), 32'd1);

    // Asynchronous reset in the middle of AL drops the pending B request.
    do_reset();
    drive(0, 1, 1, 1, 1'b1);
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      drive(0, 0, 1, 0, 1'b1);
      if (state_o == 3'd2) hit = 1;
    end
    check("reach_al", 32'(hit), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_all("reset_mid_al", 0);
    @(negedge clk);
    reset_n = 1'b1;
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 1'b1);
      if (state_o == 3'd6) hit = 1;
    end
    check("no_bl_after_reset", 32'(hit), 32'd0);
    check_all("after_reset_cycle", 0);

    // Random stimulus against the model.
    do_reset();
    model_reset();
    for (int i = 0; i < 600; i++) begin
      ra  = ($urandom_range(0, 3) != 0);
      rla = ($urandom_range(0, 9) == 0);
      rb  = ($urandom_range(0, 3) != 0);
      rlb = ($urandom_range(0, 9) == 0);
      rt  = ($urandom_range(0, 2) != 0);
      model_step(ra, rla, rb, rlb, rt);
      drive(ra, rla, rb, rlb, rt);
      check_all($sformatf("rand%0d", i), m_road * 4 + m_phase);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
